// File: rtl/datapath.sv
// 8-bit single-cycle datapath: PC, ROM, 4x8 regfile, ALU, data RAM.
// DATAPATH_R0_ZERO_EN hardwires r0 to zero.
module datapath #(
    parameter string IMEM_FILE = "program.mem",
    parameter string DMEM_FILE = ""
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] pc_out_addr,
    output logic [7:0] inst,
    output logic [7:0] result,
    output logic [7:0] readData1,
    output logic [7:0] readData2
);

    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    logic [7:0] regs [4];
    logic [7:0] pc;
    logic [7:0] pc_next;

    logic [2:0] op_code;
    logic [1:0] rs1_addr;
    logic [1:0] rs2_addr;
    logic [2:0] imm3;
    logic [7:0] imm;
    logic       ALUSrc;
    logic [1:0] alu_op;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic [7:0] mem_rdata;
    logic [7:0] mux_wb_out;
    logic       reg_we;
    logic       taken;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    end

    assign pc_out_addr = pc;
    assign inst        = imem[pc];
    assign op_code     = inst[7:5];
    assign rs1_addr    = inst[4:3];
    assign rs2_addr    = inst[2:1];
    assign imm3        = inst[2:0];

`ifdef DATAPATH_R0_ZERO_EN
    assign readData1 = (rs1_addr == 2'd0) ? 8'h00 : regs[rs1_addr];
    assign readData2 = (rs2_addr == 2'd0) ? 8'h00 : regs[rs2_addr];
    assign reg_we    = RegWrite && (rs1_addr != 2'd0);
`else
    assign readData1 = regs[rs1_addr];
    assign readData2 = regs[rs2_addr];
    assign reg_we    = RegWrite;
`endif

    always_comb begin
        ALUSrc   = 1'b0;
        alu_op   = 2'b00;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        imm      = 8'h00;
        unique case (op_code)
            3'b000: RegWrite = 1'b1;
            3'b001: begin
                alu_op   = 2'b01;
                RegWrite = 1'b1;
            end
            3'b010: begin
                alu_op   = 2'b10;
                RegWrite = 1'b1;
            end
            3'b011: begin
                alu_op   = 2'b11;
                RegWrite = 1'b1;
            end
            3'b100: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                imm      = {5'b00000, imm3};
            end
            3'b101: begin
                MemRead  = 1'b1;
                RegWrite = 1'b1;
            end
            3'b110: MemWrite = 1'b1;
            3'b111: begin
                alu_op = 2'b01;
                imm    = {{5{imm3[2]}}, imm3};
            end
        endcase
    end

    assign alu_b = ALUSrc ? imm : readData2;

    always_comb begin
        alu_result = 8'h00;
        unique case (alu_op)
            2'b00: alu_result = readData1 + alu_b;
            2'b01: alu_result = readData1 - alu_b;
            2'b10: alu_result = readData1 & alu_b;
            2'b11: alu_result = readData1 | alu_b;
        endcase
    end

    assign mem_rdata  = dmem[readData2];
    assign mux_wb_out = MemRead ? mem_rdata : alu_result;
    assign result     = mux_wb_out;

    assign taken   = (op_code == 3'b111) && (readData1 == 8'h00);
    assign pc_next = pc + 8'd1 + (taken ? imm : 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 8'h00;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (enable) begin
            pc <= pc_next;
            if (reg_we) regs[rs1_addr] <= mux_wb_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && enable && MemWrite) dmem[readData2] <= readData1;
    end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: random and directed programs
// against an instruction-level reference model.
module tb_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] pc_out_addr;
    logic [7:0] inst;
    logic [7:0] result;
    logic [7:0] readData1;
    logic [7:0] readData2;

    datapath #(
        .IMEM_FILE(""),
        .DMEM_FILE("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pc_out_addr(pc_out_addr),
        .inst       (inst),
        .result     (result),
        .readData1  (readData1),
        .readData2  (readData2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] ins;
        logic [7:0] res;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic [7:0] imm;
        logic       alusrc;
        logic [1:0] aluop;
        logic       rw;
        logic       mr;
        logic       mw;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_pc;
    logic [7:0] m_reg [4];
    logic [7:0] m_dm  [256];
    logic [7:0] m_im  [256];

    function automatic logic [7:0] rreg(input logic [1:0] idx);
`ifdef DATAPATH_R0_ZERO_EN
        if (idx == 2'd0) return 8'h00;
`endif
        return m_reg[idx];
    endfunction

    function automatic obs_t expect_now();
        obs_t       o;
        logic [7:0] i;
        logic [7:0] a;
        logic [7:0] b;
        i = m_im[m_pc];
        a = rreg(i[4:3]);
        b = rreg(i[2:1]);
        o = '0;
        o.pc  = m_pc;
        o.ins = i;
        o.rd1 = a;
        o.rd2 = b;
        case (i[7:5])
            3'd0: begin o.res = a + b; o.rw = 1; end
            3'd1: begin o.res = a - b; o.rw = 1; o.aluop = 1; end
            3'd2: begin o.res = a & b; o.rw = 1; o.aluop = 2; end
            3'd3: begin o.res = a | b; o.rw = 1; o.aluop = 3; end
            3'd4: begin
                o.imm    = 8'(i[2:0]);
                o.alusrc = 1;
                o.rw     = 1;
                o.res    = a + o.imm;
            end
            3'd5: begin o.mr = 1; o.rw = 1; o.res = m_dm[b]; end
            3'd6: begin o.mw = 1; o.res = a + b; end
            default: begin
                o.imm = 8'(i[2:0]);
                if (i[2]) o.imm = o.imm - 8'd8;
                o.aluop = 1;
                o.res   = a - b;
            end
        endcase
        return o;
    endfunction

    task automatic model_edge(input logic r, input logic e);
        obs_t o;
        if (r) begin
            m_pc = 8'h00;
            for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
        end else if (e) begin
            o = expect_now();
            if (o.ins[7:5] == 3'd7 && o.rd1 == 8'h00)
                m_pc = m_pc + 8'd1 + o.imm;
            else
                m_pc = m_pc + 8'd1;
            if (o.rw) m_reg[o.ins[4:3]] = o.res;
            if (o.mw) m_dm[o.rd2] = o.rd1;
        end
    endtask

    task automatic begin_cycle(input logic r, input logic e);
        reset  = r;
        enable = e;
        exp_q.push_back(expect_now());
        model_edge(r, e);
        #1;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic e);
        begin_cycle(r, e);
        end_cycle();
    endtask

    task automatic dchk(input string n, input logic [7:0] a,
                        input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic load(input int k, input logic [7:0] v);
        m_im[k]      = v;
        dut.imem[k]  = v;
    endtask

    // Monitor: every negedge compares DUT outputs against the queue head.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_out_addr, inst, result, readData1, readData2,
                     dut.imm, dut.ALUSrc, dut.alu_op, dut.RegWrite,
                     dut.MemRead, dut.MemWrite};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL state pc=%h: got %h want %h",
                             e.pc, a, e);
                end
            end
        end
    end

    logic [7:0] r0_exp;

    initial begin
        #1;
        for (int k = 0; k < 256; k++) begin
            m_dm[k] = 8'h00;
            load(k, 8'h00);
        end
        load(0, 8'h8D);
        load(1, 8'h93);
        load(2, 8'h0C);
        load(3, 8'h2C);
        load(4, 8'hCC);
        load(5, 8'hBC);
        load(6, 8'h87);
        load(7, 8'hE7);
        reset  = 1'b1;
        enable = 1'b0;
        model_edge(1'b1, 1'b0);
        end_cycle();

        // Reset then hold.
        for (int k = 0; k < 3; k++) begin
            begin_cycle(1'b0, 1'b0);
            dchk("hold_pc", pc_out_addr, 8'h00);
            end_cycle();
        end
        dchk("hold_rd1", readData1, 8'h00);

        begin_cycle(1'b0, 1'b1);
        dchk("addi_res", result, 8'h05);
        dchk("addi_imm", dut.imm, 8'h05);
        dchk("addi_src", 8'(dut.ALUSrc), 8'h01);
        end_cycle();
        begin_cycle(1'b0, 1'b1);
        dchk("pc1", pc_out_addr, 8'h01);
        dchk("addi2_res", result, 8'h03);
        end_cycle();
        begin_cycle(1'b0, 1'b1);
        dchk("add_res", result, 8'h08);
        dchk("add_src", 8'(dut.ALUSrc), 8'h00);
        dchk("add_op", 8'(dut.alu_op), 8'h00);
        end_cycle();
        begin_cycle(1'b0, 1'b1);
        dchk("sub_res", result, 8'h05);
        dchk("sub_op", 8'(dut.alu_op), 8'h01);
        end_cycle();
        begin_cycle(1'b0, 1'b1);
        dchk("st_mw", 8'(dut.MemWrite), 8'h01);
        dchk("st_rw", 8'(dut.RegWrite), 8'h00);
        end_cycle();
        begin_cycle(1'b0, 1'b1);
        dchk("ld_mr", 8'(dut.MemRead), 8'h01);
        dchk("ld_res", result, 8'h05);
        end_cycle();
        step(1'b0, 1'b1);
`ifdef DATAPATH_R0_ZERO_EN
        r0_exp = 8'h00;
`else
        r0_exp = 8'h07;
`endif
        begin_cycle(1'b0, 1'b1);
        dchk("r0_after_addi", readData1, r0_exp);
        end_cycle();
        dchk("beqz_next_pc", pc_out_addr,
             (r0_exp == 8'h00) ? 8'h07 : 8'h08);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);

        // Self-loop: r0 stays zero, BEQZ -1 at 0x07.
        for (int k = 0; k < 7; k++) load(k, 8'h00);
        step(1'b1, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
        dchk("beqz_loop_pc", pc_out_addr, 8'h07);

        // PC wrap with non-branch instructions.
        for (int k = 0; k < 256; k++) load(k, 8'h8D);
        step(1'b1, 1'b0);
        for (int k = 0; k < 255; k++) step(1'b0, 1'b1);
        dchk("pc_ff", pc_out_addr, 8'hFF);
        step(1'b0, 1'b1);
        dchk("pc_wrap", pc_out_addr, 8'h00);
        step(1'b0, 1'b1);

        // Random programs, random enable and occasional reset.
        for (int k = 0; k < 256; k++) load(k, 8'($urandom));
        step(1'b1, 1'b0);
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 80) ? 1'b1 : 1'b0);
            if (k == 1000)
                for (int j = 0; j < 256; j++) load(j, 8'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
